// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline clear codes and sequencing FSM state type
package rv_pipe_pkg;

    localparam logic [1:0] CTL_RUN   = 2'b00;
    localparam logic [1:0] CTL_HOLD  = 2'b01;
    localparam logic [1:0] CTL_FLUSH = 2'b11;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use comparator between the ID and EX instructions
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu      = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/bubble/flush sequencing; HAZARD_PERF_EN adds perf counters
module hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_md_start,
    input  logic       ex_branch_taken,
    input  logic       mem_trap,
    output logic       pc_en,
    output logic [1:0] ctl_ifid,
    output logic [1:0] ctl_idex,
    output logic [1:0] ctl_exmem,
    output logic [1:0] ctl_memwb
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    // The start cycle is itself the first stall, so the counter covers the rest
    localparam logic [3:0] MD_CNT_INIT = 4'(MD_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lu;
    logic       flush_evt;

    load_use_detect u_lu (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu          (lu)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_en     = 1'b1;
        ctl_ifid  = CTL_RUN;
        ctl_idex  = CTL_RUN;
        ctl_exmem = CTL_RUN;
        ctl_memwb = CTL_RUN;
        flush_evt = 1'b0;

        if (mem_trap) begin
            ctl_ifid  = CTL_FLUSH;
            ctl_idex  = CTL_FLUSH;
            ctl_exmem = CTL_FLUSH;
            state_d   = RUN;
            cnt_d     = 4'd0;
            flush_evt = 1'b1;
        end else if (state_q == MD_BUSY) begin
            if (cnt_q != 4'd0) begin
                pc_en     = 1'b0;
                ctl_ifid  = CTL_HOLD;
                ctl_idex  = CTL_HOLD;
                ctl_exmem = CTL_FLUSH;
                cnt_d     = cnt_q - 4'd1;
            end else begin
                state_d = RUN;
            end
        end else if (ex_md_start) begin
            pc_en     = 1'b0;
            ctl_ifid  = CTL_HOLD;
            ctl_idex  = CTL_HOLD;
            ctl_exmem = CTL_FLUSH;
            cnt_d     = MD_CNT_INIT;
            state_d   = MD_BUSY;
        end else if (ex_branch_taken) begin
            // Branch beats load-use: the dependent instruction is squashed anyway
            ctl_ifid  = CTL_FLUSH;
            ctl_idex  = CTL_FLUSH;
            flush_evt = 1'b1;
        end else if (lu) begin
            pc_en    = 1'b0;
            ctl_ifid = CTL_HOLD;
            ctl_idex = CTL_FLUSH;
        end

        if (rst) begin
            pc_en     = 1'b0;
            ctl_ifid  = CTL_FLUSH;
            ctl_idex  = CTL_FLUSH;
            ctl_exmem = CTL_FLUSH;
            ctl_memwb = CTL_FLUSH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, ~pc_en};
        perf_flush_d = perf_flush_q + {31'd0, flush_evt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    logic unused_flush_evt;
    assign unused_flush_evt = flush_evt;
`endif

endmodule
